// File: rtl/br_hazard_ctrl.sv
// ID-stage branch hazard scheduler: tracks EX/MEM destination shadows, drives
// branch operand forwarding selects, load-use stalls and branch counters.
module br_hazard_ctrl #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         inst_ID,
    input  logic                id_valid,
    input  logic                wreg_ID,
    input  logic [4:0]          waddr_ID,
    input  logic                is_load_ID,
    input  logic                stall_ext,
    input  logic                clr_cnt,
    output logic [1:0]          FW_br_A,
    output logic [1:0]          FW_br_B,
    output logic                stall_ID,
    output logic                br_resolve_en,
    output logic [CntWidth-1:0] stall_cnt,
    output logic [CntWidth-1:0] branch_cnt
);

    localparam logic [1:0] FW_BR_ORIGIN  = 2'b00;
    localparam logic [1:0] FW_BR_EX_ALU  = 2'b01;
    localparam logic [1:0] FW_BR_MEM_ALU = 2'b10;
    localparam logic [1:0] FW_BR_MEM_MEM = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef struct packed {
        logic       v;
        logic [4:0] waddr;
        logic       ld;
    } slot_t;

    typedef enum logic {RUN, HOLD} state_t;

    state_t              state_q, state_d;
    slot_t               ex_s_q, ex_s_d, mem_s_q, mem_s_d;
    logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d, branch_cnt_q, branch_cnt_d;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt;
    logic       is_br, is_jmp, is_jr, uses_rs, uses_rt, is_ctl, hazard;
    logic       unused_inst_bits;

    assign opcode           = inst_ID[31:26];
    assign rs               = inst_ID[25:21];
    assign rt               = inst_ID[20:16];
    assign funct            = inst_ID[5:0];
    assign unused_inst_bits = ^inst_ID[15:6];

    // Operand select for one source; an EX load hit is a hazard, so drive Origin.
    function automatic logic [1:0] fw_sel(input logic [4:0] src, input logic use_src,
                                          input slot_t ex, input slot_t mem);
        if (!use_src || src == 5'd0)        return FW_BR_ORIGIN;
        if (ex.v && ex.waddr == src)        return ex.ld ? FW_BR_ORIGIN : FW_BR_EX_ALU;
        if (mem.v && mem.waddr == src)      return mem.ld ? FW_BR_MEM_MEM : FW_BR_MEM_ALU;
        return FW_BR_ORIGIN;
    endfunction

    always_comb begin
        is_br   = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_jmp  = (opcode == OP_J) || (opcode == OP_JAL);
        is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
        uses_rs = id_valid && (is_br || is_jr);
        uses_rt = id_valid && is_br;
        is_ctl  = id_valid && (is_br || is_jmp || is_jr);

        hazard = ex_s_q.v && ex_s_q.ld &&
                 ((uses_rs && rs != 5'd0 && ex_s_q.waddr == rs) ||
                  (uses_rt && rt != 5'd0 && ex_s_q.waddr == rt));

        FW_br_A       = fw_sel(rs, uses_rs, ex_s_q, mem_s_q);
        FW_br_B       = fw_sel(rt, uses_rt, ex_s_q, mem_s_q);
        stall_ID      = hazard;
        br_resolve_en = !hazard && !stall_ext;
    end

    // Next state: slots shift, FSM tracks the bubble cycle, counters saturate.
    always_comb begin
        state_d      = state_q;
        ex_s_d       = ex_s_q;
        mem_s_d      = mem_s_q;
        stall_cnt_d  = stall_cnt_q;
        branch_cnt_d = branch_cnt_q;

        if (!stall_ext) begin
            mem_s_d = ex_s_q;
            if (stall_ID || !id_valid) begin
                ex_s_d = '0;
            end else begin
                ex_s_d.v     = wreg_ID && (waddr_ID != 5'd0);
                ex_s_d.waddr = waddr_ID;
                ex_s_d.ld    = is_load_ID;
            end

            case (state_q)
                RUN:     state_d = hazard ? HOLD : RUN;
                HOLD:    state_d = RUN;
                default: state_d = RUN;
            endcase

            if (stall_ID && stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CntWidth'(1);
            end
        end

        if (is_ctl && br_resolve_en && branch_cnt_q != '1) begin
            branch_cnt_d = branch_cnt_q + CntWidth'(1);
        end

        if (clr_cnt) begin
            stall_cnt_d  = '0;
            branch_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            ex_s_q       <= '0;
            mem_s_q      <= '0;
            stall_cnt_q  <= '0;
            branch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ex_s_q       <= ex_s_d;
            mem_s_q      <= mem_s_d;
            stall_cnt_q  <= stall_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign branch_cnt = branch_cnt_q;

endmodule

// File: tb/tb_br_hazard_ctrl.sv
// Directed bench for br_hazard_ctrl: forwarding selects, load-use stall,
// freeze, reset and counter saturation (narrow-counter instance).
module tb_br_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, id_valid, wreg_ID, is_load_ID, stall_ext, clr_cnt;
    logic [31:0] inst_ID;
    logic [4:0]  waddr_ID;
    logic [1:0]  FW_br_A, FW_br_B;
    logic        stall_ID, br_resolve_en;
    logic [15:0] stall_cnt, branch_cnt;

    logic [1:0]  sm_unused_fw_a, sm_unused_fw_b;
    logic        sm_unused_stall, sm_unused_en;
    logic [3:0]  sm_stall_cnt, sm_branch_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    br_hazard_ctrl #(.CntWidth(16)) dut (
        .clk(clk), .rst(rst), .inst_ID(inst_ID), .id_valid(id_valid),
        .wreg_ID(wreg_ID), .waddr_ID(waddr_ID), .is_load_ID(is_load_ID),
        .stall_ext(stall_ext), .clr_cnt(clr_cnt),
        .FW_br_A(FW_br_A), .FW_br_B(FW_br_B), .stall_ID(stall_ID),
        .br_resolve_en(br_resolve_en), .stall_cnt(stall_cnt), .branch_cnt(branch_cnt)
    );

    br_hazard_ctrl #(.CntWidth(4)) dut_sm (
        .clk(clk), .rst(rst), .inst_ID(inst_ID), .id_valid(id_valid),
        .wreg_ID(wreg_ID), .waddr_ID(waddr_ID), .is_load_ID(is_load_ID),
        .stall_ext(stall_ext), .clr_cnt(clr_cnt),
        .FW_br_A(sm_unused_fw_a), .FW_br_B(sm_unused_fw_b), .stall_ID(sm_unused_stall),
        .br_resolve_en(sm_unused_en), .stall_cnt(sm_stall_cnt), .branch_cnt(sm_branch_cnt)
    );

    function automatic logic [31:0] beq(input logic [4:0] s, input logic [4:0] t);
        return {6'b000100, s, t, 16'h0000};
    endfunction
    function automatic logic [31:0] bne(input logic [4:0] s, input logic [4:0] t);
        return {6'b000101, s, t, 16'h0000};
    endfunction
    function automatic logic [31:0] jr(input logic [4:0] s, input logic [4:0] t);
        return {6'b000000, s, t, 5'd0, 5'd0, 6'b001000};
    endfunction

    task automatic drive(input logic [31:0] inst, input logic v, input logic w,
                         input logic [4:0] wa, input logic ld);
        inst_ID = inst; id_valid = v; wreg_ID = w; waddr_ID = wa; is_load_ID = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ALU writer (opcode 0, add funct) and load writer (lw opcode)
    task automatic alu_to(input logic [4:0] r);
        drive(32'h0000_0020, 1'b1, 1'b1, r, 1'b0);
    endtask
    task automatic lw_to(input logic [4:0] r);
        drive({6'b100011, 5'd1, r, 16'h0004}, 1'b1, 1'b1, r, 1'b1);
    endtask
    task automatic bubble();
        drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic flush();
        bubble(); clr_cnt = 1'b1; tick(); clr_cnt = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_ext = 1'b0; clr_cnt = 1'b0;
        drive(beq(5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 1'b0);
        tick(); tick();
        checks++; if (FW_br_A !== 2'b00) begin failures++; $display("FAIL reset_fw_a got=%b exp=00", FW_br_A); end
        checks++; if (FW_br_B !== 2'b00) begin failures++; $display("FAIL reset_fw_b got=%b exp=00", FW_br_B); end
        checks++; if (stall_ID !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_ID); end
        checks++; if (br_resolve_en !== 1'b1) begin failures++; $display("FAIL reset_en got=%b exp=1", br_resolve_en); end
        checks++; if (stall_cnt !== 16'd0 || branch_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, branch_cnt); end
        bubble();
        rst = 1'b0;
    endtask

    task automatic test_alu_fwd();
        flush();
        alu_to(5'd3); tick();
        drive(beq(5'd3, 5'd4), 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (FW_br_A !== 2'b01) begin failures++; $display("FAIL alu_fw_a got=%b exp=01", FW_br_A); end
        checks++; if (FW_br_B !== 2'b00) begin failures++; $display("FAIL alu_fw_b got=%b exp=00", FW_br_B); end
        checks++; if (stall_ID !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall_ID); end
        tick(); bubble();
        checks++; if (branch_cnt !== 16'd1) begin failures++; $display("FAIL alu_branch_cnt got=%0d exp=1", branch_cnt); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL alu_stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_load_use();
        flush();
        lw_to(5'd5); tick();
        drive(bne(5'd5, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (stall_ID !== 1'b1) begin failures++; $display("FAIL lu_c1_stall got=%b exp=1", stall_ID); end
        checks++; if (br_resolve_en !== 1'b0) begin failures++; $display("FAIL lu_c1_en got=%b exp=0", br_resolve_en); end
        checks++; if (FW_br_A !== 2'b00) begin failures++; $display("FAIL lu_c1_fw_a got=%b exp=00", FW_br_A); end
        tick();
        checks++; if (FW_br_A !== 2'b11) begin failures++; $display("FAIL lu_c2_fw_a got=%b exp=11", FW_br_A); end
        checks++; if (FW_br_B !== 2'b00) begin failures++; $display("FAIL lu_c2_fw_b got=%b exp=00", FW_br_B); end
        checks++; if (stall_ID !== 1'b0) begin failures++; $display("FAIL lu_c2_stall got=%b exp=0", stall_ID); end
        checks++; if (br_resolve_en !== 1'b1) begin failures++; $display("FAIL lu_c2_en got=%b exp=1", br_resolve_en); end
        tick(); bubble();
        checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        checks++; if (branch_cnt !== 16'd1) begin failures++; $display("FAIL lu_branch_cnt got=%0d exp=1", branch_cnt); end
    endtask

    task automatic test_r0();
        flush();
        alu_to(5'd0); tick();
        drive(beq(5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (FW_br_A !== 2'b00 || FW_br_B !== 2'b00) begin failures++; $display("FAIL r0_fw got=%b/%b exp=00/00", FW_br_A, FW_br_B); end
        checks++; if (stall_ID !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b exp=0", stall_ID); end
        tick(); bubble();
    endtask

    task automatic test_order();
        flush();
        alu_to(5'd7); tick();
        lw_to(5'd7); tick();
        drive(jr(5'd7, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (stall_ID !== 1'b1) begin failures++; $display("FAIL ord_stall got=%b exp=1", stall_ID); end
        tick();
        checks++; if (FW_br_A !== 2'b11) begin failures++; $display("FAIL ord_fw_a got=%b exp=11", FW_br_A); end
        checks++; if (stall_ID !== 1'b0) begin failures++; $display("FAIL ord_stall2 got=%b exp=0", stall_ID); end
        tick(); bubble();
    endtask

    task automatic test_jr_gating();
        flush();
        lw_to(5'd5); tick();
        drive(jr(5'd6, 5'd5), 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (stall_ID !== 1'b0) begin failures++; $display("FAIL jr_stall got=%b exp=0", stall_ID); end
        checks++; if (FW_br_B !== 2'b00) begin failures++; $display("FAIL jr_fw_b got=%b exp=00", FW_br_B); end
        checks++; if (br_resolve_en !== 1'b1) begin failures++; $display("FAIL jr_en got=%b exp=1", br_resolve_en); end
        tick(); bubble();
    endtask

    task automatic test_freeze();
        flush();
        lw_to(5'd5); tick();
        drive(bne(5'd5, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        stall_ext = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (stall_ID !== 1'b1) begin failures++; $display("FAIL frz_stall_%0d got=%b exp=1", i, stall_ID); end
            checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL frz_cnt_%0d got=%0d exp=0", i, stall_cnt); end
        end
        checks++; if (br_resolve_en !== 1'b0) begin failures++; $display("FAIL frz_en got=%b exp=0", br_resolve_en); end
        stall_ext = 1'b0; #1;
        tick();
        checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL frz_cnt_after got=%0d exp=1", stall_cnt); end
        checks++; if (FW_br_A !== 2'b11 || stall_ID !== 1'b0) begin failures++; $display("FAIL frz_resume got=%b/%b exp=11/0", FW_br_A, stall_ID); end
        tick(); bubble();
    endtask

    task automatic test_reset_mid_stall();
        flush();
        lw_to(5'd5); tick();
        drive(bne(5'd5, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
        checks++; if (stall_ID !== 1'b1) begin failures++; $display("FAIL rms_pre got=%b exp=1", stall_ID); end
        rst = 1'b1; tick(); rst = 1'b0; #1;
        checks++; if (stall_ID !== 1'b0 || FW_br_A !== 2'b00) begin failures++; $display("FAIL rms_post got=%b/%b exp=0/00", stall_ID, FW_br_A); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rms_cnt got=%0d exp=0", stall_cnt); end
        bubble();
    endtask

    task automatic test_saturate_clear();
        flush();
        for (int i = 0; i < 20; i++) begin
            lw_to(5'd5); tick();
            drive(beq(5'd5, 5'd5), 1'b1, 1'b0, 5'd0, 1'b0); tick();
        end
        bubble();
        checks++; if (stall_cnt !== 16'd20) begin failures++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
        checks++; if (sm_stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_narrow got=%0h exp=f", sm_stall_cnt); end
        checks++; if (branch_cnt !== 16'd0) begin failures++; $display("FAIL sat_branch got=%0d exp=0", branch_cnt); end
        lw_to(5'd5); tick();
        drive(beq(5'd5, 5'd5), 1'b1, 1'b0, 5'd0, 1'b0); tick();
        bubble();
        checks++; if (sm_stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold got=%0h exp=f", sm_stall_cnt); end
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        checks++; if (stall_cnt !== 16'd0 || sm_stall_cnt !== 4'h0) begin failures++; $display("FAIL clr got=%0d/%0d exp=0/0", stall_cnt, sm_stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_r0();
        test_order();
        test_jr_gating();
        test_freeze();
        test_reset_mid_stall();
        test_saturate_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
